ctrl_bus_arbiter: RTL and testbench

CTRL_BUS_ARBITER -- requirements
Module: ctrl_bus_arbiter

---
 rtl/ctrl_bus_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/ctrl_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_ctrl_bus_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_bus_pkg.sv
// ctrl_bus_pkg: FSM encoding and default sizes shared by
// the control-bus arbiter and its round-robin selector.
package ctrl_bus_pkg;

  localparam int CTRL_ADDR_W  = 8;
  localparam int CTRL_DATA_W  = 8;
  localparam int CTRL_TIMEOUT = 16;
  localparam int CTRL_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic rw_ok(
    input logic rd,
    input logic wr
  );
    return rd ^ wr;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching
// upward from last+1 with wrap; one-hot and index out.
module rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  localparam int IDX_W = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       idx,
  output logic                   valid
);

  int j;

  // Walk the distances far-to-near so the nearest hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int s = NUM_MASTERS; s >= 1; s--) begin
      j = int'(last) + s;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      if (req[j]) begin
        grant = NUM_MASTERS'(1) << j;
        idx   = IDX_W'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrl_bus_arbiter.sv
// ctrl_bus_arbiter: round-robin control-bus master arbiter.
// Define CTRL_BUS_TIMEOUT_EN to build the bus_ack timeout.
module ctrl_bus_arbiter
  import ctrl_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = CTRL_ADDR_W,
  parameter int DATA_W      = CTRL_DATA_W,
  parameter int TIMEOUT     = CTRL_TIMEOUT
) (
  input  logic                          mclk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_grant,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [ADDR_W-1:0]             bus_addr,
  output logic [DATA_W-1:0]             bus_wdata,
  output logic                          bus_read,
  output logic                          bus_write,
  input  logic [DATA_W-1:0]             bus_rdata,
  input  logic                          bus_ack
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  state_t                 state;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic                   pick_valid;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic                   sel_rd;
  logic                   sel_wr;
`ifdef CTRL_BUS_TIMEOUT_EN
  logic [CTRL_CNT_W-1:0]  xfer_cnt;
`endif

  rr_arbiter #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_rr (
    .req   (m_req),
    .last  (last_grant),
    .grant (pick_oh),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_oh[i]) begin
        sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = m_wdata[i*DATA_W +: DATA_W];
        sel_rd    = m_read[i];
        sel_wr    = m_write[i];
      end
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= IDX_W'(NUM_MASTERS - 1);
      m_grant    <= '0;
      m_ack      <= '0;
      m_err      <= '0;
      m_rdata    <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_read   <= 1'b0;
      bus_write  <= 1'b0;
`ifdef CTRL_BUS_TIMEOUT_EN
      xfer_cnt   <= '0;
`endif
    end else begin
      m_ack <= '0;
      m_err <= '0;
      unique case (state)
        ST_IDLE: begin
          m_grant <= '0;
`ifdef CTRL_BUS_TIMEOUT_EN
          xfer_cnt <= '0;
`endif
          if (pick_valid) begin
            last_grant <= pick_idx;
            m_grant    <= pick_oh;
            bus_addr   <= sel_addr;
            bus_wdata  <= sel_wdata;
            // Ambiguous direction never reaches the target.
            if (rw_ok(sel_rd, sel_wr)) begin
              bus_read  <= sel_rd;
              bus_write <= sel_wr;
              state     <= ST_XFER;
            end else begin
              m_err <= pick_oh;
              state <= ST_DONE;
            end
          end
        end
        ST_XFER: begin
          if (bus_ack) begin
            if (bus_read) m_rdata <= bus_rdata;
            m_ack     <= m_grant;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            state     <= ST_DONE;
          end
`ifdef CTRL_BUS_TIMEOUT_EN
          else if (xfer_cnt == CTRL_CNT_W'(TIMEOUT - 1)) begin
            m_err     <= m_grant;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            state     <= ST_DONE;
          end else begin
            xfer_cnt <= xfer_cnt + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          m_grant <= '0;
          state   <= ST_IDLE;
        end
        default: begin
          m_grant   <= '0;
          bus_read  <= 1'b0;
          bus_write <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_bus_arbiter.sv
// tb_ctrl_bus_arbiter: directed scenarios, then random
// traffic against a round-robin transaction model.
module tb_ctrl_bus_arbiter;

  localparam int N   = 2;
  localparam int TMO = 16;

  logic         mclk;
  logic         rst_n;
  logic [N-1:0] m_req;
  logic [N-1:0] m_read;
  logic [N-1:0] m_write;
  logic [N*8-1:0] m_addr;
  logic [N*8-1:0] m_wdata;
  logic [N-1:0] m_grant;
  logic [N-1:0] m_ack;
  logic [N-1:0] m_err;
  logic [7:0]   m_rdata;
  logic [7:0]   bus_addr;
  logic [7:0]   bus_wdata;
  logic         bus_read;
  logic         bus_write;
  logic [7:0]   bus_rdata;
  logic         bus_ack;

  int checks = 0;
  int errors = 0;

  // model state
  int ph;
  int own;
  int last;
  int cyc;
  logic [N-1:0] e_grant, e_ack, e_err;
  logic         e_rd, e_wr;
  logic [7:0]   e_addr, e_wdata, e_rdata;

  ctrl_bus_arbiter #(
    .NUM_MASTERS(N),
    .ADDR_W(8),
    .DATA_W(8),
    .TIMEOUT(TMO)
  ) dut (
    .mclk      (mclk),
    .rst_n     (rst_n),
    .m_req     (m_req),
    .m_read    (m_read),
    .m_write   (m_write),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_grant   (m_grant),
    .m_ack     (m_ack),
    .m_err     (m_err),
    .m_rdata   (m_rdata),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_read  (bus_read),
    .bus_write (bus_write),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(
    input string t,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", t, obs, exp);
    end
  endtask

  task automatic set_master(
    input int i,
    input logic rd,
    input logic wr,
    input logic [7:0] a,
    input logic [7:0] d
  );
    m_read[i]       = rd;
    m_write[i]      = wr;
    m_addr[i*8 +: 8]  = a;
    m_wdata[i*8 +: 8] = d;
  endtask

  task automatic rnd_master(input int i);
    int k;
    k = $urandom_range(7, 0);
    if (k == 0) set_master(i, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
    else if (k == 1) set_master(i, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
    else if (k < 5) set_master(i, 1'b1, 1'b0, 8'($urandom), 8'($urandom));
    else set_master(i, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    m_req = '0;
    bus_ack = 1'b0;
    @(negedge mclk);
    @(negedge mclk);
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    ph = 0; own = -1; last = N - 1; cyc = 0;
    e_grant = '0; e_ack = '0; e_err = '0;
    e_rd = 1'b0; e_wr = 1'b0;
    e_addr = '0; e_wdata = '0; e_rdata = '0;
  endtask

  // Predicts the outputs after the coming rising edge.
  task automatic model_step();
    int s, c;
    e_ack = '0;
    e_err = '0;
    if (ph == 2) begin
      e_grant = '0;
      ph = 0;
    end else if (ph == 1) begin
      if (bus_ack) begin
        if (e_rd) e_rdata = bus_rdata;
        e_ack[own] = 1'b1;
        e_rd = 1'b0; e_wr = 1'b0;
        ph = 2;
      end
`ifdef CTRL_BUS_TIMEOUT_EN
      else begin
        cyc++;
        if (cyc == TMO) begin
          e_err[own] = 1'b1;
          e_rd = 1'b0; e_wr = 1'b0;
          ph = 2;
        end
      end
`endif
    end else begin
      e_grant = '0;
      own = -1;
      for (s = 1; s <= N; s++) begin
        c = (last + s) % N;
        if (own < 0 && m_req[c]) own = c;
      end
      if (own >= 0) begin
        last = own;
        e_grant[own] = 1'b1;
        e_addr = m_addr[own*8 +: 8];
        e_wdata = m_wdata[own*8 +: 8];
        if (m_read[own] != m_write[own]) begin
          e_rd = m_read[own];
          e_wr = m_write[own];
          cyc = 0;
          ph = 1;
        end else begin
          e_err[own] = 1'b1;
          ph = 2;
        end
      end
    end
  endtask

  task automatic check_all(input string t);
    chk({t, ".grant"}, 32'(m_grant), 32'(e_grant));
    chk({t, ".ack"}, 32'(m_ack), 32'(e_ack));
    chk({t, ".err"}, 32'(m_err), 32'(e_err));
    chk({t, ".rw"}, {30'd0, bus_read, bus_write}, {30'd0, e_rd, e_wr});
    chk({t, ".addr"}, 32'(bus_addr), 32'(e_addr));
    chk({t, ".wdata"}, 32'(bus_wdata), 32'(e_wdata));
    chk({t, ".rdata"}, 32'(m_rdata), 32'(e_rdata));
  endtask

  initial begin
    int cnt;
    logic seen;
    rst_n = 1'b0;
    m_req = '0; m_read = '0; m_write = '0;
    m_addr = '0; m_wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;

    // reset values
    @(negedge mclk);
    @(negedge mclk);
    chk("rst.grant", 32'(m_grant), 0);
    chk("rst.ackerr", 32'({m_ack, m_err}), 0);
    chk("rst.rw", 32'({bus_read, bus_write}), 0);
    chk("rst.addr", 32'({bus_addr, bus_wdata}), 0);
    chk("rst.rdata", 32'(m_rdata), 0);
    rst_n = 1'b1;

    // single write, acked on 2nd XFER cycle
    set_master(0, 1'b0, 1'b1, 8'h12, 8'hA5);
    m_req = 2'b01;
    @(negedge mclk);
    chk("wr.x1.write", 32'(bus_write), 1);
    chk("wr.x1.read", 32'(bus_read), 0);
    chk("wr.x1.addr", 32'(bus_addr), 32'h12);
    chk("wr.x1.wdata", 32'(bus_wdata), 32'hA5);
    chk("wr.x1.grant", 32'(m_grant), 1);
    @(negedge mclk);
    chk("wr.x2.write", 32'(bus_write), 1);
    chk("wr.x2.addr", 32'(bus_addr), 32'h12);
    chk("wr.x2.ack", 32'(m_ack), 0);
    bus_ack = 1'b1;
    @(negedge mclk);
    chk("wr.d.ack", 32'(m_ack), 1);
    chk("wr.d.err", 32'(m_err), 0);
    chk("wr.d.write", 32'(bus_write), 0);
    chk("wr.d.grant", 32'(m_grant), 1);
    m_req = '0; bus_ack = 1'b0;
    @(negedge mclk);
    chk("wr.i.grant", 32'(m_grant), 0);
    chk("wr.i.ack", 32'(m_ack), 0);

    // two masters contending, target acks at once
    reset_dut();
    set_master(0, 1'b0, 1'b1, 8'h20, 8'h01);
    set_master(1, 1'b0, 1'b1, 8'h21, 8'h02);
    m_req = 2'b11; bus_ack = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge mclk);
      chk("rr.x.grant", 32'(m_grant), 32'(1 << (t % 2)));
      chk("rr.x.write", 32'(bus_write), 1);
      @(negedge mclk);
      chk("rr.d.ack", 32'(m_ack), 32'(1 << (t % 2)));
      if (t == 3) m_req = '0;
      @(negedge mclk);
      chk("rr.i.grant", 32'(m_grant), 0);
    end
    bus_ack = 1'b0;

    // master 1 read
    set_master(1, 1'b1, 1'b0, 8'h40, 8'h00);
    m_req = 2'b10; bus_ack = 1'b1; bus_rdata = 8'h5C;
    @(negedge mclk);
    chk("rd.x.grant", 32'(m_grant), 2);
    chk("rd.x.rw", 32'({bus_read, bus_write}), 2);
    chk("rd.x.addr", 32'(bus_addr), 32'h40);
    @(negedge mclk);
    chk("rd.d.ack", 32'(m_ack), 2);
    chk("rd.d.rdata", 32'(m_rdata), 32'h5C);
    chk("rd.d.read", 32'(bus_read), 0);
    m_req = '0; bus_rdata = 8'hFF;
    @(negedge mclk);
    chk("rd.i.rdata", 32'(m_rdata), 32'h5C);
    chk("rd.i.read", 32'(bus_read), 0);
    chk("rd.i.ack", 32'(m_ack), 0);
    bus_ack = 1'b0;
    @(negedge mclk);
    chk("rd.i2.rdata", 32'(m_rdata), 32'h5C);

    // direction conflict
    set_master(0, 1'b1, 1'b1, 8'h77, 8'h00);
    m_req = 2'b01;
    @(negedge mclk);
    chk("cf.rw", 32'({bus_read, bus_write}), 0);
    chk("cf.err", 32'(m_err), 1);
    chk("cf.ack", 32'(m_ack), 0);
    chk("cf.grant", 32'(m_grant), 1);
    m_req = '0;
    @(negedge mclk);
    chk("cf.i.err", 32'(m_err), 0);
    chk("cf.i.grant", 32'(m_grant), 0);

    // asynchronous reset in XFER
    set_master(0, 1'b1, 1'b0, 8'h33, 8'h00);
    m_req = 2'b01;
    @(negedge mclk);
    chk("ar.x.read", 32'(bus_read), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.read", 32'(bus_read), 0);
    chk("ar.grant", 32'(m_grant), 0);
    chk("ar.ackerr", 32'({m_ack, m_err}), 0);
    @(negedge mclk);
    rst_n = 1'b1;
    set_master(1, 1'b0, 1'b1, 8'h44, 8'h55);
    m_req = 2'b11;
    @(negedge mclk);
    chk("ar.first", 32'(m_grant), 1);
    bus_ack = 1'b1;
    @(negedge mclk);
    chk("ar.ack", 32'(m_ack), 1);
    m_req = '0; bus_ack = 1'b0;
    @(negedge mclk);

    // target never acks
    set_master(0, 1'b1, 1'b0, 8'h50, 8'h00);
    m_req = 2'b01;
    cnt = 0;
    seen = 1'b0;
`ifdef CTRL_BUS_TIMEOUT_EN
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge mclk);
      if (bus_read) cnt++;
      if (m_err[0]) seen = 1'b1;
    end
    chk("to.cycles", 32'(cnt), TMO);
    chk("to.err", 32'(seen), 1);
    m_req = '0;
    @(negedge mclk);
    chk("to.i.err", 32'(m_err), 0);
    chk("to.i.grant", 32'(m_grant), 0);
`else
    for (int c = 0; c < 100; c++) begin
      @(negedge mclk);
      if (bus_read) cnt++;
      if (m_err != '0) seen = 1'b1;
    end
    chk("hang.cycles", 32'(cnt), 100);
    chk("hang.err", 32'(seen), 0);
`endif

    // random traffic against the model
    reset_dut();
    model_reset();
    check_all("rnd0");
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (e_ack[i] || e_err[i]) begin
          if ($urandom_range(1, 0) == 0) m_req[i] = 1'b0;
          else rnd_master(i);
        end else if (!m_req[i]) begin
          if ($urandom_range(2, 0) == 0) begin
            rnd_master(i);
            m_req[i] = 1'b1;
          end
        end else if (ph == 1 && own == i) begin
          if ($urandom_range(9, 0) == 0) m_req[i] = 1'b0;
        end
      end
      bus_ack = ($urandom_range(2, 0) == 0);
      bus_rdata = 8'($urandom);
      model_step();
      @(negedge mclk);
      check_all("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
